// File: rtl/bp_pkg.sv
// Shared types for the branch-resolution controller slice.
//   ctrl_state_e : controller FSM states (RUN, FLUSH)
//   bp_entry_t   : one outstanding prediction at the default PC width
//   DEFAULT_PC_W : default PC / target width
package bp_pkg;

  localparam int unsigned DEFAULT_PC_W = 32;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } ctrl_state_e;

  typedef struct packed {
    logic                    taken;
    logic [DEFAULT_PC_W-1:0] target;
    logic [DEFAULT_PC_W-1:0] fallthru;
  } bp_entry_t;

endpackage

// File: rtl/branch_fifo.sv
// In-order queue of outstanding branch predictions.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   push_i       : append din_i (ignored when full)
//   pop_i        : drop the oldest entry (ignored when empty)
//   clear_i      : synchronous flush of all entries; dominates push/pop
//   din_i        : entry to append
//   dout_o       : oldest entry (valid when !empty_o)
//   count_o      : current occupancy
//   full_o       : occupancy == DEPTH
//   empty_o      : occupancy == 0
module branch_fifo
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter type         entry_t = bp_entry_t
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       clear_i,
  input  entry_t                     din_i,
  output entry_t                     dout_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               do_push;
  logic               do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem[rd_ptr_q];

  always_comb begin
    do_push = push_i && !full_o && !clear_i;
    do_pop  = pop_i && !empty_o && !clear_i;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Sequences the 2-bit branch predictor: queues predictions made in ID,
// checks them against EX outcomes, drives predictor update, pipeline flush,
// PC redirect, and keeps branch / mispredict statistics.
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   pred_valid_i        : ID predicted a conditional branch this cycle
//   pred_taken_i        : prediction used
//   pred_target_i       : branch target PC
//   pred_fallthru_i     : PC+4 of the branch
//   stall_i             : ID stalled, prediction not accepted
//   res_valid_i         : EX resolves the oldest outstanding branch
//   res_taken_i         : actual outcome
//   full_o              : queue full, ID must stall branches
//   upd_o, upd_result_o : predictor update strobe and outcome
//   flush_o             : squash IF/ID
//   redirect_valid_o    : one-cycle redirect strobe
//   redirect_pc_o       : corrected PC
//   err_o               : sticky protocol error
//   branch_cnt_o        : resolved branches
//   mispred_cnt_o       : mispredicted branches
module branch_resolve_ctrl
  import bp_pkg::*;
#(
  parameter int unsigned PC_W         = DEFAULT_PC_W,
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pred_valid_i,
  input  logic             pred_taken_i,
  input  logic [PC_W-1:0]  pred_target_i,
  input  logic [PC_W-1:0]  pred_fallthru_i,
  input  logic             stall_i,
  input  logic             res_valid_i,
  input  logic             res_taken_i,
  output logic             full_o,
  output logic             upd_o,
  output logic             upd_result_o,
  output logic             flush_o,
  output logic             redirect_valid_o,
  output logic [PC_W-1:0]  redirect_pc_o,
  output logic             err_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic            taken;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] fallthru;
  } entry_t;

  ctrl_state_e      state_q, state_d;
  logic [2:0]       flush_cnt_q, flush_cnt_d;

  entry_t           push_entry;
  entry_t           head;
  logic [OCC_W-1:0] occ;
  logic             fifo_full;
  logic             fifo_empty;

  logic             in_run;
  logic             push_req;
  logic             resolve;
  logic             mispred;
  logic             push_ok;
  logic             err_set;

  assign push_entry = '{taken: pred_taken_i, target: pred_target_i, fallthru: pred_fallthru_i};

  always_comb begin
    in_run   = (state_q == RUN);
    push_req = pred_valid_i && !stall_i && in_run;
    resolve  = res_valid_i && in_run && !fifo_empty;
    mispred  = resolve && (res_taken_i != head.taken);
    // A mispredict wipes the queue, so a same-edge push is wrong-path.
    push_ok  = push_req && !fifo_full && !mispred;
    err_set  = (push_req && fifo_full && !mispred) ||
               (res_valid_i && in_run && fifo_empty);
  end

  branch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_ok),
    .pop_i   (resolve && !mispred),
    .clear_i (mispred),
    .din_i   (push_entry),
    .dout_o  (head),
    .count_o (occ),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign full_o  = (occ == OCC_W'(DEPTH));
  assign flush_o = (state_q == FLUSH);

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    unique case (state_q)
      RUN: begin
        if (mispred) begin
          state_d     = FLUSH;
          flush_cnt_d = 3'(FLUSH_CYCLES);
        end
      end
      FLUSH: begin
        if (flush_cnt_q <= 3'd1) begin
          state_d     = RUN;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q - 3'd1;
        end
      end
      default: begin
        state_d     = RUN;
        flush_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      upd_o            <= 1'b0;
      upd_result_o     <= 1'b0;
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= '0;
      err_o            <= 1'b0;
      branch_cnt_o     <= '0;
      mispred_cnt_o    <= '0;
    end else begin
      upd_o            <= resolve;
      redirect_valid_o <= mispred;
      if (resolve) begin
        upd_result_o <= res_taken_i;
        branch_cnt_o <= branch_cnt_o + CNT_W'(1);
      end
      if (mispred) begin
        redirect_pc_o <= res_taken_i ? head.target : head.fallthru;
        mispred_cnt_o <= mispred_cnt_o + CNT_W'(1);
      end
      if (err_set) err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
module tb_branch_resolve_ctrl;

  localparam int unsigned PC_W = 32;
  localparam int unsigned CW   = 4;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b0;
  logic            pred_valid_i = 1'b0;
  logic            pred_taken_i = 1'b0;
  logic [PC_W-1:0] pred_target_i = '0;
  logic [PC_W-1:0] pred_fallthru_i = '0;
  logic            stall_i = 1'b0;
  logic            res_valid_i = 1'b0;
  logic            res_taken_i = 1'b0;
  logic            full_o, upd_o, upd_result_o, flush_o, redirect_valid_o, err_o;
  logic [PC_W-1:0] redirect_pc_o;
  logic [CW-1:0]   branch_cnt_o, mispred_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  branch_resolve_ctrl #(
    .PC_W         (PC_W),
    .DEPTH        (2),
    .FLUSH_CYCLES (3),
    .CNT_W        (CW)
  ) u_dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .pred_valid_i     (pred_valid_i),
    .pred_taken_i     (pred_taken_i),
    .pred_target_i    (pred_target_i),
    .pred_fallthru_i  (pred_fallthru_i),
    .stall_i          (stall_i),
    .res_valid_i      (res_valid_i),
    .res_taken_i      (res_taken_i),
    .full_o           (full_o),
    .upd_o            (upd_o),
    .upd_result_o     (upd_result_o),
    .flush_o          (flush_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .err_o            (err_o),
    .branch_cnt_o     (branch_cnt_o),
    .mispred_cnt_o    (mispred_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        pv, pt;
    logic [31:0] tgt, ft;
    logic        st, rv, rt;
    logic        full, upd, ures, flush, rdv;
    logic [31:0] pc;
    logic        err;
    logic [3:0]  bc, mc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic pv, input logic pt, input logic [31:0] tgt,
                       input logic [31:0] ft, input logic st, input logic rv, input logic rt);
    pred_valid_i    = pv;
    pred_taken_i    = pt;
    pred_target_i   = tgt;
    pred_fallthru_i = ft;
    stall_i         = st;
    res_valid_i     = rv;
    res_taken_i     = rt;
  endtask

  // Apply current inputs across one rising edge, then idle the inputs.
  task automatic step();
    @(posedge clk_i);
    #1;
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic push(input logic pt, input logic [31:0] tgt, input logic [31:0] ft);
    drive(1, pt, tgt, ft, 0, 0, 0);
    step();
  endtask

  task automatic resolve(input logic rt);
    drive(0, 0, 0, 0, 0, 1, rt);
    step();
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic add(input logic pv, pt, input logic [31:0] tgt, ft, input logic st, rv, rt,
                     input logic full, upd, ures, flush, rdv, input logic [31:0] pc,
                     input logic err, input logic [3:0] bc, mc);
    vec_t v;
    v = '{pv, pt, tgt, ft, st, rv, rt, full, upd, ures, flush, rdv, pc, err, bc, mc};
    vecs.push_back(v);
  endtask

  initial begin
    //   pv pt tgt     ft      st rv rt | full upd ures flush rdv pc      err bc mc
    add(1, 1, 'h40,  'h14,  0, 0, 0,   0,   0,  0,   0,    0,  'h0,    0,  0, 0); // push
    add(1, 0, 'hAA,  'hBB,  1, 0, 0,   0,   0,  0,   0,    0,  'h0,    0,  0, 0); // stalled push
    add(0, 0, 0,     0,     0, 1, 1,   0,   1,  1,   0,    0,  'h0,    0,  1, 0); // correct resolve
    add(0, 0, 0,     0,     0, 0, 0,   0,   0,  0,   0,    0,  'h0,    0,  1, 0);
    add(1, 1, 'h80,  'h24,  0, 0, 0,   0,   0,  0,   0,    0,  'h0,    0,  1, 0);
    add(1, 0, 'h90,  'h34,  0, 0, 0,   1,   0,  0,   0,    0,  'h0,    0,  1, 0); // full
    add(0, 0, 0,     0,     0, 1, 0,   0,   1,  0,   1,    1,  'h24,   0,  2, 1); // mispredict NT
    add(0, 0, 0,     0,     0, 0, 0,   0,   0,  0,   1,    0,  'h24,   0,  2, 1);
    add(0, 0, 0,     0,     0, 1, 1,   0,   0,  0,   1,    0,  'h24,   0,  2, 1); // resolve in flush
    add(1, 1, 'hA0,  'hA4,  0, 0, 0,   0,   0,  0,   0,    0,  'h24,   0,  2, 1); // push in flush
    add(0, 0, 0,     0,     0, 1, 1,   0,   0,  0,   0,    0,  'h24,   1,  2, 1); // resolve empty
    add(0, 0, 0,     0,     0, 0, 0,   0,   0,  0,   0,    0,  'h24,   1,  2, 1);
    add(1, 1, 'h100, 'h104, 0, 0, 0,   0,   0,  0,   0,    0,  'h24,   1,  2, 1);
    add(1, 0, 'h200, 'h204, 0, 0, 0,   1,   0,  0,   0,    0,  'h24,   1,  2, 1);
    add(1, 1, 'h300, 'h304, 0, 0, 0,   1,   0,  0,   0,    0,  'h24,   1,  2, 1); // push full
    add(1, 1, 'h400, 'h404, 0, 1, 1,   0,   1,  1,   0,    0,  'h24,   1,  3, 1); // push+pop full
    add(1, 0, 'h500, 'h504, 0, 1, 0,   0,   1,  0,   0,    0,  'h24,   1,  4, 1); // push+pop occ 1
    add(0, 0, 0,     0,     0, 1, 1,   0,   1,  1,   1,    1,  'h500,  1,  5, 2); // mispredict T
    add(0, 0, 0,     0,     0, 0, 0,   0,   0,  0,   1,    0,  'h500,  1,  5, 2);
    add(0, 0, 0,     0,     0, 0, 0,   0,   0,  0,   1,    0,  'h500,  1,  5, 2);
    add(0, 0, 0,     0,     0, 0, 0,   0,   0,  0,   0,    0,  'h500,  1,  5, 2);

    // Reset state
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    chk("rst full", full_o, 0);
    chk("rst upd", upd_o, 0);
    chk("rst flush", flush_o, 0);
    chk("rst redir", redirect_valid_o, 0);
    chk("rst pc", redirect_pc_o, 0);
    chk("rst err", err_o, 0);
    chk("rst bcnt", branch_cnt_o, 0);
    chk("rst mcnt", mispred_cnt_o, 0);
    do_reset();

    // Vector table
    foreach (vecs[i]) begin
      drive(vecs[i].pv, vecs[i].pt, vecs[i].tgt, vecs[i].ft, vecs[i].st, vecs[i].rv, vecs[i].rt);
      step();
      chk($sformatf("v%0d full", i), full_o, vecs[i].full);
      chk($sformatf("v%0d upd", i), upd_o, vecs[i].upd);
      if (vecs[i].upd) chk($sformatf("v%0d ures", i), upd_result_o, vecs[i].ures);
      chk($sformatf("v%0d flush", i), flush_o, vecs[i].flush);
      chk($sformatf("v%0d redir", i), redirect_valid_o, vecs[i].rdv);
      chk($sformatf("v%0d pc", i), redirect_pc_o, vecs[i].pc);
      chk($sformatf("v%0d err", i), err_o, vecs[i].err);
      chk($sformatf("v%0d bcnt", i), branch_cnt_o, vecs[i].bc);
      chk($sformatf("v%0d mcnt", i), mispred_cnt_o, vecs[i].mc);
    end

    // Asynchronous reset in the 2nd flush cycle
    do_reset();
    resolve(1);                 // empty -> err
    push(1, 'h40, 'h14);
    resolve(0);                 // mispredict, 1st flush cycle follows
    chk("mf flush1", flush_o, 1);
    chk("mf redir1", redirect_valid_o, 1);
    chk("mf pc", redirect_pc_o, 'h14);
    step();                     // 2nd flush cycle
    chk("mf flush2", flush_o, 1);
    #3;
    rst_i = 1'b1;
    #1;
    chk("mf rst flush", flush_o, 0);
    chk("mf rst redir", redirect_valid_o, 0);
    chk("mf rst upd", upd_o, 0);
    chk("mf rst bcnt", branch_cnt_o, 0);
    chk("mf rst mcnt", mispred_cnt_o, 0);
    chk("mf rst err", err_o, 0);
    chk("mf rst pc", redirect_pc_o, 0);
    #1;
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    chk("mf post full", full_o, 0);
    push(1, 'h40, 'h14);
    resolve(1);
    chk("mf post upd", upd_o, 1);
    chk("mf post ures", upd_result_o, 1);
    chk("mf post flush", flush_o, 0);
    chk("mf post bcnt", branch_cnt_o, 1);
    chk("mf post err", err_o, 0);

    // Push while full: dropped, err sticky, contents unchanged
    do_reset();
    push(1, 'h10, 'h14);
    push(0, 'h20, 'h24);
    chk("pf full", full_o, 1);
    chk("pf err0", err_o, 0);
    push(1, 'h30, 'h34);
    chk("pf err1", err_o, 1);
    chk("pf full2", full_o, 1);
    chk("pf upd", upd_o, 0);
    resolve(1);                 // oldest: taken
    chk("pf r1 flush", flush_o, 0);
    chk("pf r1 upd", upd_o, 1);
    resolve(0);                 // next: not taken
    chk("pf r2 flush", flush_o, 0);
    chk("pf r2 redir", redirect_valid_o, 0);
    chk("pf r2 full", full_o, 0);
    chk("pf r2 bcnt", branch_cnt_o, 2);
    chk("pf r2 mcnt", mispred_cnt_o, 0);
    chk("pf err sticky", err_o, 1);

    // Counter wrap at CNT_W=4
    do_reset();
    for (int i = 0; i < 17; i++) begin
      push(1, 32'h1000 + 32'(i), 32'h2000 + 32'(i));
      resolve(1);
    end
    chk("wrap bcnt", branch_cnt_o, 1);
    chk("wrap mcnt", mispred_cnt_o, 0);
    chk("wrap flush", flush_o, 0);
    chk("wrap err", err_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
- Sequences the 2-bit branch predictor inside the pipelined CPU.
- Records each prediction made in ID in an in-order queue of outstanding branches, and compares it against the actual outcome resolved in EX.
- Drives the predictor's update/result inputs and asserts the pipeline flush.
- Issues the corrected PC redirect on a mispredict, and keeps prediction statistics.

Parameters:
- PC_W, 32, PC and target width.
- DEPTH, 2, maximum outstanding (predicted, unresolved) branches; power of two, >=2.
- FLUSH_CYCLES, 1, cycles flush_o stays high after a mispredict; range 1..7.
- CNT_W, 16, width of statistics counters.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- pred_valid_i  in  1  ID holds a conditional branch that has been predicted this cycle.
- pred_taken_i  in  1  predictor output used for that branch.
- pred_target_i  in  PC_W  branch target PC.
- pred_fallthru_i  in  PC_W  PC+4 of the branch.
- stall_i  in  1  ID stalled; a prediction is not accepted.
- res_valid_i  in  1  EX resolves the oldest outstanding branch.
- res_taken_i  in  1  actual outcome.
- full_o  out  1  queue full; ID must stall further branches.
- upd_o  out  1  predictor update_i.
- upd_result_o  out  1  predictor result_i (1 = taken).
- flush_o  out  1  squash IF/ID (wrong-path instructions).
- redirect_valid_o  out  1  one-cycle PC redirect strobe.
- redirect_pc_o  out  PC_W  corrected PC.
- err_o  out  1  sticky protocol error.
- branch_cnt_o  out  CNT_W  resolved branches.
- mispred_cnt_o  out  CNT_W  mispredicted branches.

Behaviour:
- Reset (async, any time, including mid-flush):
  - Queue emptied; state RUN.
  - All outputs 0, counters 0, err_o 0.
- Push: on the clock edge where pred_valid_i && !stall_i && state==RUN && !full_o, append {pred_taken_i, pred_target_i, pred_fallthru_i}.
  - Push while full: entry dropped, err_o set.
- Resolve: on the edge where res_valid_i && state==RUN && queue non-empty:
  - Pop the oldest entry.
  - Increment branch_cnt_o.
  - Mispredict = res_taken_i != entry.taken.
- Resolve with the queue empty in RUN: ignored, err_o set.
- Resolve during FLUSH: ignored silently; it is wrong-path.
- Push and resolve on the same edge: both take effect; occupancy unchanged. full_o is evaluated before the pop, so a push while full is still dropped.
- full_o is combinational from the occupancy count (== DEPTH).
- Latency: resolve sampled at edge N gives registered outputs valid during cycle N+1:
  - upd_o=1 for exactly one cycle, on every resolve (correct or not).
  - upd_result_o = res_taken_i.
- Mispredict at edge N:
  - mispred_cnt_o increments.
  - State goes to FLUSH with flush counter = FLUSH_CYCLES.
  - Queue cleared entirely; all younger entries are wrong-path. A push on the same edge is discarded and does not set err_o.
  - redirect_valid_o=1 for cycle N+1 only.
  - redirect_pc_o = entry.target if res_taken_i, else entry.fallthru. It holds its last value otherwise.
- FSM states:
  - RUN: flush_o=0. Mispredict goes to FLUSH.
  - FLUSH: flush_o=1. Counter decrements each edge; at 1, the next edge returns to RUN.
  - flush_o is high for exactly FLUSH_CYCLES cycles starting N+1.
  - Pushes and resolves are ignored in FLUSH.
- Counters wrap modulo 2^CNT_W. They do not saturate.
- err_o clears only on reset.

Decomposition:
- Shared package (bp_pkg):
  - ctrl_state_e {RUN, FLUSH}.
  - bp_entry_t struct {taken, target[PC_W], fallthru[PC_W]}.
  - Default PC_W.
- Sub-module: branch_fifo, a DEPTH-entry synchronous FIFO of bp_entry_t with push, pop, synchronous clear, count, full and empty.
- The controller FSM, outputs and counters stay in branch_resolve_ctrl.

Test Plan:
- Reset mid-flush:
  - Setup: FLUSH_CYCLES=3; mispredict; assert rst_i asynchronously in the 2nd flush cycle.
  - Required: flush_o, redirect_valid_o, upd_o, counters and err_o drop to 0 immediately; after release, full_o=0 and a new push/resolve works.
- Correct prediction:
  - Stimulus: push {taken=1, target=0x40, fallthru=0x14}; resolve res_taken=1 two cycles later.
  - Required: upd_o=1 and upd_result_o=1 for one cycle; flush_o=0; redirect_valid_o=0; branch_cnt_o=1; mispred_cnt_o=0.
- Mispredict not-taken:
  - Stimulus: push {taken=1, target=0x80, fallthru=0x24}, then a second push (queue full, full_o=1); resolve res_taken=0.
  - Required next cycle: redirect_valid_o=1 with redirect_pc_o=0x24; flush_o=1 for 1 cycle; queue empty (full_o=0); mispred_cnt_o=1.
- Simultaneous push and resolve at DEPTH=2 with one entry present:
  - Required: occupancy stays 1; the FIFO order of the popped and remaining entries is verified by a following resolve.
- Protocol errors:
  - Stimulus: res_valid_i with the queue empty, or pred_valid_i while full_o=1.
  - Required: err_o=1 and sticky; queue contents unchanged; no upd_o.
- Counter wrap:
  - Setup: CNT_W=4; 17 correct resolves.
  - Required: branch_cnt_o=1; mispred_cnt_o=0.
